// File: rtl/instr_fetch_seq.sv
// 8086 prefetch sequencer: fetches code words into a byte queue and cuts complete
// instructions from the queue head, using the length reported by the external decoder.
module instr_fetch_seq #(
  parameter int          QDEPTH   = 8,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iFlush,
  input  logic [15:0] iFlushIP,
  output logic        oMemReq,
  output logic [15:0] oMemAddr,
  input  logic        iMemAck,
  input  logic [15:0] iMemData,
  output logic [7:0]  oLdOp0,
  output logic [7:0]  oLdOp1,
  input  logic [2:0]  iLdLen,
  output logic        oInsValid,
  input  logic        iInsReady,
  output logic [47:0] oInsBytes,
  output logic [2:0]  oInsLen,
  output logic [15:0] oInsIP
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;

  logic [7:0]    r_q [QDEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] w_wr1;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_push_n;
  logic [CW-1:0] w_pop_n;
  logic [15:0]   r_ip;
  logic [15:0]   r_fetch_addr;
  logic [15:0]   r_hold_addr;
  logic          r_drop_low;
  logic          w_room;
  logic          w_push;
  logic          w_load;
  logic [47:0]   w_head_bytes;

  // A new word is only requested when both of its bytes are guaranteed a slot.
  assign w_room   = (r_count <= CW'(QDEPTH - 2));
  assign w_load   = (!oInsValid || iInsReady) && (r_count >= CW'(2)) &&
                    (r_count >= CW'(iLdLen)) && !iFlush;
  assign w_pop_n  = w_load ? CW'(iLdLen) : '0;
  assign w_push_n = !w_push ? '0 : (r_drop_low ? CW'(1) : CW'(2));
  assign w_wr1    = r_wr + PW'(1);

  assign oLdOp0   = r_q[r_rd];
  assign oLdOp1   = r_q[r_rd + PW'(1)];
  assign oMemReq  = (r_state != S_IDLE);
  // A discarded request keeps presenting its original address until the bus acks it.
  assign oMemAddr = (r_state == S_DISCARD) ? r_hold_addr : r_fetch_addr;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!iFlush && w_room) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (iMemAck) begin
          w_state_nxt = S_IDLE;
          w_push      = !iFlush;
        end else if (iFlush) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (iMemAck) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_head_bytes = '0;
    for (int i = 0; i < 6; i++) begin
      if (3'(i) < iLdLen) w_head_bytes[i*8 +: 8] = r_q[r_rd + PW'(i)];
    end
  end

  // NOTE: queue storage carries no reset; r_count alone decides which bytes are live.
  always_ff @(posedge iClk) begin
    if (w_push) begin
      if (r_drop_low) begin
        r_q[r_wr] <= iMemData[15:8];
      end else begin
        r_q[r_wr] <= iMemData[7:0];
        r_q[w_wr1] <= iMemData[15:8];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_rd         <= '0;
      r_wr         <= '0;
      r_ip         <= RESET_IP;
      r_fetch_addr <= {RESET_IP[15:1], 1'b0};
      r_hold_addr  <= {RESET_IP[15:1], 1'b0};
      r_drop_low   <= RESET_IP[0];
      oInsValid    <= 1'b0;
      oInsBytes    <= '0;
      oInsLen      <= '0;
      oInsIP       <= RESET_IP;
    end else begin
      r_state <= w_state_nxt;
      if (iFlush) begin
        r_count      <= '0;
        r_rd         <= '0;
        r_wr         <= '0;
        r_ip         <= iFlushIP;
        r_fetch_addr <= {iFlushIP[15:1], 1'b0};
        r_drop_low   <= iFlushIP[0];
        oInsValid    <= 1'b0;
        if (r_state == S_REQ && !iMemAck) r_hold_addr <= r_fetch_addr;
      end else begin
        r_count <= r_count + w_push_n - w_pop_n;
        r_rd    <= r_rd + PW'(w_pop_n);
        r_wr    <= r_wr + PW'(w_push_n);
        if (w_push) begin
          r_drop_low   <= 1'b0;
          r_fetch_addr <= r_fetch_addr + 16'd2;
        end
        if (w_load) begin
          oInsValid <= 1'b1;
          oInsBytes <= w_head_bytes;
          oInsLen   <= iLdLen;
          oInsIP    <= r_ip;
          r_ip      <= r_ip + 16'(iLdLen);
        end else if (iInsReady) begin
          oInsValid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: a byte-addressed code memory with random ack latency and an
// instruction-stream reference model that walks memory from the expected IP.
module tb_instr_fetch_seq;

  logic        iClk;
  logic        iRst;
  logic        iFlush;
  logic [15:0] iFlushIP;
  logic        oMemReq;
  logic [15:0] oMemAddr;
  logic        iMemAck;
  logic [15:0] iMemData;
  logic [7:0]  oLdOp0;
  logic [7:0]  oLdOp1;
  logic [2:0]  iLdLen;
  logic        oInsValid;
  logic        iInsReady;
  logic [47:0] oInsBytes;
  logic [2:0]  oInsLen;
  logic [15:0] oInsIP;

  int          total = 0;
  int          bad   = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] log_q [$];
  logic [15:0] m_ip;
  int          max_delay = 3;
  logic        block_en  = 1'b0;
  logic [15:0] block_addr = 16'h0000;

  instr_fetch_seq #(.QDEPTH(8), .RESET_IP(16'h0000)) dut (
    .iClk(iClk), .iRst(iRst), .iFlush(iFlush), .iFlushIP(iFlushIP),
    .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemAck(iMemAck), .iMemData(iMemData),
    .oLdOp0(oLdOp0), .oLdOp1(oLdOp1), .iLdLen(iLdLen),
    .oInsValid(oInsValid), .iInsReady(iInsReady),
    .oInsBytes(oInsBytes), .oInsLen(oInsLen), .oInsIP(oInsIP)
  );

  // Length decoder stand-in: a few real 8086 opcodes, everything else 1..6 from the opcode.
  function automatic logic [2:0] ld_len(input logic [7:0] b0, input logic [7:0] b1);
    case (b0)
      8'h90, 8'hC3, 8'hAA: return 3'd1;
      8'h89, 8'hEB:        return 3'd2;
      8'h81:               return (b1 == 8'h06) ? 3'd6 : 3'd4;
      default:             return 3'(b0 % 8'd6) + 3'd1;
    endcase
  endfunction

  assign iLdLen = ld_len(oLdOp0, oLdOp1);

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Code memory: acks a pending request after a random wait, unless that address is blocked.
  initial begin
    int wait_cnt;
    iMemAck  = 1'b0;
    iMemData = 16'h0000;
    wait_cnt = 0;
    forever begin
      @(negedge iClk);
      iMemAck = 1'b0;
      if (iRst || !oMemReq) begin
        wait_cnt = int'($urandom_range(0, max_delay));
      end else if (!(block_en && oMemAddr == block_addr)) begin
        if (wait_cnt == 0) begin
          iMemAck  = 1'b1;
          iMemData = {mem[oMemAddr + 16'd1], mem[oMemAddr]};
          log_q.push_back(oMemAddr);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic expect_stream(input int n, input int pct, input int budget);
    int          got = 0;
    logic [2:0]  e_len;
    logic [47:0] e_bytes;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge iClk);
      iInsReady = (int'($urandom_range(0, 99)) < pct);
      if (oInsValid && iInsReady) begin
        e_len   = ld_len(mem[m_ip], mem[m_ip + 16'd1]);
        e_bytes = '0;
        for (int k = 0; k < int'(e_len); k++) e_bytes[k*8 +: 8] = mem[m_ip + 16'(k)];
        total++;
        if ({oInsLen, oInsIP, oInsBytes} !== {e_len, m_ip, e_bytes}) begin
          bad++;
          $display("FAIL instr: got len=%0d ip=%h bytes=%h, want len=%0d ip=%h bytes=%h",
                   oInsLen, oInsIP, oInsBytes, e_len, m_ip, e_bytes);
        end
        m_ip = m_ip + 16'(e_len);
        got++;
      end
    end
    @(negedge iClk);
    iInsReady = 1'b0;
    total++;
    if (got != n) begin
      bad++;
      $display("FAIL stream_count: got %0d instructions, want %0d", got, n);
    end
  endtask

  task automatic do_flush(input logic [15:0] ip);
    @(negedge iClk);
    iInsReady = 1'b0;
    iFlush    = 1'b1;
    iFlushIP  = ip;
    @(negedge iClk);
    iFlush = 1'b0;
    m_ip   = ip;
  endtask

  task automatic quiesce();
    int quiet = 0;
    iInsReady = 1'b0;
    for (int c = 0; c < 300 && quiet < 8; c++) begin
      @(negedge iClk);
      quiet = oMemReq ? 0 : quiet + 1;
    end
    total++;
    if (quiet < 8) begin
      bad++;
      $display("FAIL quiesce: fetch never stopped with consumer stalled");
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iFlush = 1'b0; iFlushIP = 16'h0000; iInsReady = 1'b0;
    repeat (3) @(negedge iClk);
    total++;
    if ({oMemReq, oMemAddr, oInsValid, oInsBytes, oInsLen, oInsIP} !==
        {1'b0, 16'h0000, 1'b0, 48'h0, 3'd0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_values: req=%b addr=%h v=%b bytes=%h len=%0d ip=%h, want all zero",
               oMemReq, oMemAddr, oInsValid, oInsBytes, oInsLen, oInsIP);
    end
    log_q.delete();
    iRst = 1'b0;
    m_ip = 16'h0000;
  endtask

  task automatic test_first_fetch();
    bit found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge iClk);
      if (iMemAck) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL first_ack: no ack within 30 cycles");
    end
    @(negedge iClk);
    total++;
    if (oInsValid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: valid=%b one cycle after ack, want 0", oInsValid);
    end
    @(negedge iClk);
    total++;
    if (oInsValid !== 1'b1) begin
      bad++;
      $display("FAIL latency: valid=%b two cycles after ack, want 1", oInsValid);
    end
    expect_stream(2, 100, 100);
    total++;
    if (log_q.size() < 2 || log_q[0] !== 16'h0000 || log_q[1] !== 16'h0002) begin
      bad++;
      $display("FAIL first_addrs: got %0d requests first=%h second=%h, want 0000 0002",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : 16'hxxxx,
               (log_q.size() > 1) ? log_q[1] : 16'hxxxx);
    end
  endtask

  task automatic test_mixed_lengths();
    logic [7:0] prog [8];
    prog = '{8'h89, 8'hD8, 8'h81, 8'h06, 8'h34, 8'h12, 8'h78, 8'h56};
    for (int i = 0; i < 8; i++) mem[i] = prog[i];
    do_flush(16'h0000);
    expect_stream(4, 100, 200);
  endtask

  task automatic test_flush_discard();
    quiesce();
    mem[16'h0100] = 8'hAA;
    mem[16'h0101] = 8'hC3;
    block_addr = 16'h0004;
    block_en   = 1'b1;
    do_flush(16'h0000);
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 60 && !hit; c++) begin
        @(negedge iClk);
        if (oMemReq && oMemAddr == 16'h0004) hit = 1'b1;
      end
      total++;
      if (!hit) begin
        bad++;
        $display("FAIL discard_setup: request to 0004 never seen");
      end
    end
    do_flush(16'h0101);
    log_q.delete();
    total++;
    if ({oMemReq, oMemAddr} !== {1'b1, 16'h0004}) begin
      bad++;
      $display("FAIL discard_hold: req=%b addr=%h, want 1 0004", oMemReq, oMemAddr);
    end
    block_en = 1'b0;
    expect_stream(3, 100, 100);
    total++;
    if (log_q.size() < 2 || log_q[0] !== 16'h0004 || log_q[1] !== 16'h0100) begin
      bad++;
      $display("FAIL refetch_addr: got %0d requests, want 0004 then 0100", log_q.size());
    end
  endtask

  task automatic test_full_stall();
    int req_late = 0;
    do_flush(16'h0200);
    expect_stream(3, 100, 100);
    iInsReady = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge iClk);
      if (c >= 40 && oMemReq) req_late++;
    end
    total++;
    if (req_late != 0) begin
      bad++;
      $display("FAIL full_no_req: request active %0d cycles with queue full, want 0", req_late);
    end
    total++;
    if ({oInsValid, oInsIP} !== {1'b1, m_ip}) begin
      bad++;
      $display("FAIL stall_hold: valid=%b ip=%h, want 1 %h", oInsValid, oInsIP, m_ip);
    end
    expect_stream(20, 100, 300);
  endtask

  task automatic test_addr_wrap();
    mem[16'hFFFE] = 8'hEB;
    mem[16'hFFFF] = 8'h00;
    mem[16'h0000] = 8'h90;
    mem[16'h0001] = 8'h90;
    quiesce();
    log_q.delete();
    do_flush(16'hFFFE);
    expect_stream(2, 100, 100);
    total++;
    if (log_q.size() < 2 || log_q[0] !== 16'hFFFE || log_q[1] !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_addrs: got %0d requests, want FFFE then 0000", log_q.size());
    end
  endtask

  task automatic test_reset_mid_req();
    bit hit = 1'b0;
    block_addr = 16'h0304;
    block_en   = 1'b1;
    do_flush(16'h0300);
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge iClk);
      if (oInsValid && oMemReq && oMemAddr == 16'h0304) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL mid_req_setup: never saw valid output with request 0304 pending");
    end
    #1;
    iRst     = 1'b1;
    block_en = 1'b0;
    #1;
    total++;
    if ({oMemReq, oMemAddr, oInsValid, oInsBytes, oInsLen, oInsIP} !==
        {1'b0, 16'h0000, 1'b0, 48'h0, 3'd0, 16'h0000}) begin
      bad++;
      $display("FAIL async_reset: req=%b addr=%h v=%b bytes=%h len=%0d ip=%h, want all zero",
               oMemReq, oMemAddr, oInsValid, oInsBytes, oInsLen, oInsIP);
    end
    log_q.delete();
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    m_ip = 16'h0000;
    expect_stream(4, 100, 150);
    total++;
    if (log_q.size() < 1 || log_q[0] !== 16'h0000) begin
      bad++;
      $display("FAIL reset_refetch: first request after reset not at 0000");
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int r = 0; r < 6; r++) begin
      max_delay = int'($urandom_range(0, 4));
      do_flush(16'($urandom));
      expect_stream(30, int'($urandom_range(20, 100)), 3000);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h90;
    test_reset();
    test_first_fetch();
    test_mixed_lengths();
    test_flush_discard();
    test_full_stall();
    test_addr_wrap();
    test_reset_mid_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
